// File: rtl/exp_bias_sched_pkg.sv
// Shared vecunit definitions for the exponent bias scheduler: widths, FSM state
// type, per-lane result record and the next-active-lane search.
package exp_bias_sched_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAX_LANES = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } exp_sched_state_e;

    typedef struct packed {
        logic [EXP_W-1:0] diff;
        logic             borrow;
        logic             uflow;
    } lane_res_t;

    // Lowest set bit of mask at position >= from.
    // Returns {found, index}; found=0 means no active lane remains.
    function automatic logic [4:0] next_lane(input logic [MAX_LANES-1:0] mask,
                                             input logic [4:0]           from);
        logic [4:0] res;
        res = '0;
        // Scan downwards so the lowest qualifying lane is the last one written.
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/exp_bias_sched_sub.sv
// Shared 8-bit exponent bias subtractor: A - B via two's complement add,
// with carry-out as borrow and an underflow flag taken from the raw sum.
module exp_bias_sched_sub
    import exp_bias_sched_pkg::*;
(
    input  logic [EXP_W-1:0] a_i,
    input  logic [EXP_W-1:0] b_i,
    output logic [EXP_W-1:0] diff_o,
    output logic             borrow_o,
    output logic             uflow_o
);

    logic [EXP_W-1:0] b_neg;
    logic [EXP_W:0]   sum;
    logic [EXP_W-1:0] raw;

    // Combinational subtract; a zero exponent (zero/denormal) forces diff to 0.
    always_comb begin
        b_neg    = ~b_i + 8'd1;
        sum      = {1'b0, a_i} + {1'b0, b_neg};
        raw      = sum[EXP_W-1:0];
        diff_o   = (a_i == '0) ? '0 : raw;
        // B=0 negates to 0, so no carry: borrow is 1 only for B!=0 and A>=B.
        borrow_o = sum[EXP_W];
        // Flag uses the unmasked raw sum, not diff_o.
        uflow_o  = ~raw[EXP_W-1] & ~(&raw[EXP_W-2:0]);
    end

endmodule

// File: rtl/exp_bias_sched.sv
// Exponent bias scheduler: time-multiplexes one bias subtractor across the
// active lanes of a vector in ascending lane order, then presents the
// assembled per-lane results over a valid/ready handshake.
module exp_bias_sched
    import exp_bias_sched_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned EW    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [LANES*EW-1:0] exp_a_i,
    input  logic [EW-1:0]       bias_i,
    input  logic [LANES-1:0]    lane_mask_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*EW-1:0] diff_o,
    output logic [LANES-1:0]    borrow_o,
    output logic [LANES-1:0]    uflow_o,
    output logic                uflow_any_o,
    output logic                busy_o
);

    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

    exp_sched_state_e state_q, state_d;

    logic [LANES*EW-1:0] exp_q, exp_d;
    logic [EW-1:0]       bias_q, bias_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic [IdxW-1:0]     idx_q, idx_d;

    logic [LANES*EW-1:0] diff_q, diff_d;
    logic [LANES-1:0]    borrow_q, borrow_d;
    logic [LANES-1:0]    uflow_q, uflow_d;
    logic                uflow_any_q, uflow_any_d;

    logic [4:0] first_nx;
    logic [4:0] run_nx;
    logic       unused_nx;

    logic [EXP_W-1:0] sub_a;
    logic [EXP_W-1:0] sub_diff;
    logic             sub_borrow;
    logic             sub_uflow;
    lane_res_t        sub_res;

    // Lane search: first active lane of the incoming mask, and the next active
    // lane above the one currently in the subtractor.
    always_comb begin
        first_nx = next_lane(MAX_LANES'(lane_mask_i), 5'd0);
        run_nx   = next_lane(MAX_LANES'(mask_q), 5'(idx_q) + 5'd1);
    end

    // Upper index bits beyond IdxW are always zero for in-range lanes.
    assign unused_nx = ^{first_nx, run_nx};

    // Operand mux in front of the shared subtractor.
    always_comb begin
        sub_a = exp_q[idx_q*EW +: EW];
    end

    exp_bias_sched_sub u_sub (
        .a_i     (sub_a),
        .b_i     (bias_q),
        .diff_o  (sub_diff),
        .borrow_o(sub_borrow),
        .uflow_o (sub_uflow)
    );

    assign sub_res = '{diff: sub_diff, borrow: sub_borrow, uflow: sub_uflow};

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = (lane_mask_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!run_nx[4]) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs decode the state register directly.
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    // Datapath next state: operand capture on accept, result demux during RUN.
    always_comb begin
        exp_d    = exp_q;
        bias_d   = bias_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        uflow_d  = uflow_q;

        if (flush_i) begin
            diff_d   = '0;
            borrow_d = '0;
            uflow_d  = '0;
        end else if (state_q == IDLE && in_valid_i) begin
            exp_d    = exp_a_i;
            bias_d   = bias_i;
            mask_d   = lane_mask_i;
            idx_d    = first_nx[IdxW-1:0];
            diff_d   = '0;
            borrow_d = '0;
            uflow_d  = '0;
        end else if (state_q == RUN) begin
            diff_d[idx_q*EW +: EW] = sub_res.diff;
            borrow_d[idx_q]        = sub_res.borrow;
            uflow_d[idx_q]         = sub_res.uflow;
            idx_d                  = run_nx[IdxW-1:0];
        end

        uflow_any_d = |uflow_d;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q       <= '0;
            bias_q      <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= '0;
            uflow_q     <= '0;
            uflow_any_q <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            bias_q      <= bias_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            uflow_q     <= uflow_d;
            uflow_any_q <= uflow_any_d;
        end
    end

    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
    assign uflow_o     = uflow_q;
    assign uflow_any_o = uflow_any_q;

endmodule

// File: tb/tb_exp_bias_sched.sv
// Bench for exp_bias_sched: transaction-level model plus per-cycle compare,
// and directed scenarios with hand-computed literal results.
module tb_exp_bias_sched;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] exp_a = '0;
    logic [7:0]  bias = '0;
    logic [3:0]  mask = '0;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] diff;
    logic [3:0]  borrow;
    logic [3:0]  uflow;
    logic        uflow_any;
    logic        busy;

    int tests = 0;
    int fails = 0;

    exp_bias_sched #(
        .LANES(LANES),
        .EW   (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .exp_a_i    (exp_a),
        .bias_i     (bias),
        .lane_mask_i(mask),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .diff_o     (diff),
        .borrow_o   (borrow),
        .uflow_o    (uflow),
        .uflow_any_o(uflow_any),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {diff[31:0], borrow[3:0], uflow[3:0]} from plain integer arithmetic.
    function automatic logic [39:0] model_vec(input logic [31:0] a, input logic [7:0] b,
                                              input logic [3:0] m);
        logic [31:0] d;
        logic [3:0]  br;
        logic [3:0]  uf;
        d  = '0;
        br = '0;
        uf = '0;
        for (int i = 0; i < LANES; i++) begin
            int av;
            int bv;
            int raw;
            av = int'(a[8*i +: 8]);
            bv = int'(b);
            raw = (av - bv + 256) % 256;
            if (m[i]) begin
                d[8*i +: 8] = (av == 0) ? 8'd0 : 8'(raw);
                br[i] = (bv != 0) && (av >= bv);
                uf[i] = (raw < 128) && ((raw % 128) != 127);
            end
        end
        return {d, br, uf};
    endfunction

    // Transaction model: 0=idle, 1=working (k cycles), 2=result offered.
    int          m_st = 0;
    int          m_cnt = 0;
    logic [39:0] m_res = '0;
    logic [39:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st   <= 0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (flush) begin
            m_st  <= 0;
            m_res <= '0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_res <= '0;
                    if (mask == 4'b0000) begin
                        m_st <= 2;
                    end else begin
                        m_st   <= 1;
                        m_cnt  <= $countones(mask);
                        m_pend <= model_vec(exp_a, bias, mask);
                    end
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_st  <= 2;
                        m_res <= m_pend;
                    end
                end
                2: if (out_ready) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model; results are only settled outside the work phase.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(m_st == 0));
            check("out_valid", 32'(out_valid), 32'(m_st == 2));
            check("busy", 32'(busy), 32'(m_st != 0));
            if (m_st != 1) begin
                check("diff", diff, m_res[39:8]);
                check("borrow", 32'(borrow), 32'(m_res[7:4]));
                check("uflow", 32'(uflow), 32'(m_res[3:0]));
                check("uflow_any", 32'(uflow_any), 32'(|m_res[3:0]));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] b, input logic [3:0] m);
        @(negedge clk);
        exp_a    = a;
        bias     = b;
        mask     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        #1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] d, input logic [3:0] br,
                                input logic [3:0] uf, input logic any);
        check({tag, "_diff"}, diff, d);
        check({tag, "_borrow"}, 32'(borrow), 32'(br));
        check({tag, "_uflow"}, 32'(uflow), 32'(uf));
        check({tag, "_uany"}, 32'(uflow_any), 32'(any));
    endtask

    localparam logic [31:0] A1 = 32'h907F_0500;

    initial begin
        int lat;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_result("rst", 32'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: all lanes
        send(A1, 8'h7F, 4'b1111);
        wait_valid(lat);
        check("s1_lat", 32'(lat), 32'd4);
        check_result("s1", 32'h1100_8600, 4'b1100, 4'b1100, 1'b1);
        check("s1_model", m_res[39:8], 32'h1100_8600);
        take();

        // Scenario 2: sparse mask
        send(A1, 8'h7F, 4'b0101);
        wait_valid(lat);
        check("s2_lat", 32'(lat), 32'd2);
        check_result("s2", 32'h0, 4'b0100, 4'b0100, 1'b1);
        take();

        // Scenario 3: empty mask
        send(A1, 8'h7F, 4'b0000);
        wait_valid(lat);
        check("s3_lat", 32'(lat), 32'd0);
        check_result("s3", 32'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("s3_busy_held", 32'(busy), 32'd1);
        take();
        #1;
        check("s3_busy_drop", 32'(busy), 32'd0);

        // Scenario 4: consumer stall with a competing input offered
        send(A1, 8'h7F, 4'b1111);
        wait_valid(lat);
        check("s4_lat", 32'(lat), 32'd4);
        @(negedge clk);
        exp_a    = 32'hFFFF_FFFF;
        bias     = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check("s4_hold_diff", diff, 32'h1100_8600);
            check("s4_hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take();
        check("s4_ready_back", 32'(in_ready), 32'd1);
        check_result("s4_idle", 32'h1100_8600, 4'b1100, 4'b1100, 1'b1);

        // Scenario 5: flush mid-run, then a fresh single-lane op
        send(A1, 8'h7F, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("s5_no_valid", 32'(out_valid), 32'd0);
            check("s5_cleared", diff, 32'h0);
        end
        send(32'h0000_0080, 8'h7F, 4'b0001);
        wait_valid(lat);
        check("s5b_lat", 32'(lat), 32'd1);
        check_result("s5b", 32'h0000_0001, 4'b0001, 4'b0001, 1'b1);
        take();

        // Scenario 6: asynchronous reset mid-run, then rerun scenario 2
        send(A1, 8'h7F, 4'b1111);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("s6_in_ready", 32'(in_ready), 32'd1);
        check("s6_out_valid", 32'(out_valid), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check_result("s6_rst", 32'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send(A1, 8'h7F, 4'b0101);
        wait_valid(lat);
        check("s6b_lat", 32'(lat), 32'd2);
        check_result("s6b", 32'h0, 4'b0100, 4'b0100, 1'b1);
        take();

        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/exp_bias_sched.md
Name: exp_bias_sched

Overview:
- Sequencer that time-multiplexes one shared 8-bit exponent bias subtractor across the lanes of a vector FP operation in the vecunit.
- Accepts a vector of biased exponents plus a common bias, feeds active lanes through the subtractor one per cycle in ascending lane order, and collects per-lane difference, borrow and underflow.
- Returns the assembled vector result over a valid/ready handshake.

Parameters:
LANES, 4, number of vector lanes (power of two, 2..16)
EW, 8, exponent width; fixed at 8 to match the subtractor datapath

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous abort of the current operation
in_valid_i  in  1  operand vector valid
in_ready_o  out  1  block can accept an operand vector
exp_a_i  in  LANES*8  per-lane exponent; lane i at [8i+7:8i]
bias_i  in  8  common bias (subtrahend) applied to all lanes
lane_mask_i  in  LANES  1 = lane active
out_valid_o  out  1  result vector valid
out_ready_i  in  1  consumer accepts result
diff_o  out  LANES*8  per-lane difference, same packing as exp_a_i
borrow_o  out  LANES  per-lane carry-out of the subtractor
uflow_o  out  LANES  per-lane underflow flag
uflow_any_o  out  1  OR of uflow_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_ni=0, async): state IDLE; operand, mask, index and result registers cleared. Outputs: in_ready_o=1, out_valid_o=0, diff_o/borrow_o/uflow_o/uflow_any_o=0, busy_o=0. Same effect at any point mid-operation.
- Subtractor per lane (A=lane exponent, B=bias):
  - raw = (A + ((~B)+1)) mod 256.
  - diff = (A==0) ? 0 : raw.
  - borrow = carry-out of A + (((~B)+1) mod 256), i.e. 1 iff B!=0 and A>=B.
  - uflow = ~raw[7] & ~&raw[6:0]. This uses raw, not the masked diff.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o at edge t:
    - latch exp_a_i, bias_i, lane_mask_i; clear result registers.
    - idx = lowest set mask bit.
    - mask==0 goes to DONE; otherwise goes to RUN.
  - RUN: each cycle drive lane idx into the subtractor and write its results into slot idx on the next edge.
    - idx advances to the next higher set mask bit.
    - After the highest active lane is written, go to DONE.
    - Inactive lanes keep diff=0, borrow=0, uflow=0.
  - DONE: out_valid_o=1 with results stable. On out_valid_o & out_ready_i, go to IDLE. Results are held until the next accept.
- Latency: with k active lanes accepted at edge t, out_valid_o is high from edge t+k (k=0: from edge t). Minimum initiation interval is k+2 cycles. in_ready_o is low outside IDLE; there is no overlap.
- flush_i (sampled at the edge, any state): state goes to IDLE, out_valid_o=0, results cleared.
  - flush_i wins over a simultaneous in_valid_i (no accept) or out_ready_i.
  - flush_i in IDLE only clears the results.
- Outputs are registered, except in_ready_o, out_valid_o and busy_o, which decode state directly.
- in_valid_i while not in IDLE is ignored; the driver must hold it.

Decomposition:
- Shared vecunit package holds:
  - EXP_W=8
  - the state enum exp_sched_state_e {IDLE,RUN,DONE}
  - the lane-result struct {diff[7:0], borrow, uflow}.
- Sub-module: the existing bias_Substractor (8-bit combinational A−B with Difference/Borrow_out/underflow), instantiated once. The scheduler provides the mux in front of it and the result demux behind it.
- Next-active-lane search is a combinational priority encoder function in the package.

Test Plan:
1. mask=4'b1111, bias=0x7F, lanes0..3 A={0x00,0x05,0x7F,0x90}:
   - out_valid_o rises 4 cycles after accept.
   - diff={0x00,0x86,0x00,0x11}, borrow={0,0,1,1}, uflow={0,0,1,1}, uflow_any_o=1.
2. mask=4'b0101, same operands:
   - out_valid_o after 2 cycles.
   - lanes 0,2 as in scenario 1; lanes 1,3 diff=0, borrow=0, uflow=0.
   - uflow_any_o=1 (lane 2).
3. mask=4'b0000: out_valid_o high immediately after the accept edge; all results 0; busy_o high until out_ready_i.
4. Scenario 1 with out_ready_i low for 5 cycles:
   - diff_o/flags stable, in_ready_o=0, in_valid_i ignored.
   - out_ready_i pulses 1 cycle, then IDLE and in_ready_o=1 next cycle.
5. flush_i one cycle after the 2nd RUN edge of scenario 1:
   - IDLE next edge, out_valid_o never rises, results 0.
   - A following op (mask=4'b0001, A=0x80, bias=0x7F) gives diff=0x01, borrow=1, uflow=1.
6. rst_ni low asynchronously mid-RUN (between edges):
   - outputs immediately go to reset values.
   - After release, scenario 2 rerun produces identical results.
